// File: rtl/muldiv_pkg.sv
// Shared RV32M multiply/divide decode: funct3 encodings, FSM states and signedness helpers.
package muldiv_pkg;

  localparam int unsigned F3_W = 3;

  typedef enum logic [F3_W-1:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  function automatic logic is_signed_a(input funct3_e f);
    return (f == F3_MULH) || (f == F3_MULHSU) || (f == F3_DIV) || (f == F3_REM);
  endfunction

  function automatic logic is_signed_b(input funct3_e f);
    return (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
  endfunction

  function automatic logic is_div(input funct3_e f);
    return (f == F3_DIV) || (f == F3_DIVU) || (f == F3_REM) || (f == F3_REMU);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on magnitudes,
// sharing one 2*WIDTH accumulator and one WIDTH+1-bit adder/subtractor.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             kill_i,
  input  logic [2:0]       funct3_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned AW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           r_state, w_state_nxt;
  funct3_e          r_f3;
  logic [AW-1:0]    r_acc;
  logic [WIDTH-1:0] r_mag_b;
  logic [CW-1:0]    r_cnt;
  logic             r_neg;
  logic             r_sa;
  logic [WIDTH-1:0] r_result;

  logic             w_start;
  logic             w_done;

  // Operand decode at issue
  funct3_e          w_f3_in;
  logic             w_sa, w_sb;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;
  logic             w_div_zero, w_ovf, w_fast;
  logic [AW-1:0]    w_fast_acc;

  assign w_f3_in    = funct3_e'(funct3_i);
  assign w_sa       = is_signed_a(w_f3_in) & op_a_i[WIDTH-1];
  assign w_sb       = is_signed_b(w_f3_in) & op_b_i[WIDTH-1];
  assign w_mag_a    = w_sa ? (~op_a_i + WIDTH'(1)) : op_a_i;
  assign w_mag_b    = w_sb ? (~op_b_i + WIDTH'(1)) : op_b_i;
  assign w_div_zero = is_div(w_f3_in) && (op_b_i == '0);
  assign w_ovf      = ((w_f3_in == F3_DIV) || (w_f3_in == F3_REM)) &&
                      (op_a_i == MIN_INT) && (&op_b_i);
  assign w_fast     = w_div_zero | w_ovf;
  // Fast-path results are parked in the accumulator as {remainder, quotient}
  assign w_fast_acc = w_div_zero ? {op_a_i, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, MIN_INT};

  // Shared adder: hi+b for multiply, {rem,next bit}-b for divide
  logic             w_is_div;
  logic [WIDTH:0]   w_trial, w_add_a, w_add_b, w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [AW-1:0]    w_acc_mul, w_acc_div;

  assign w_is_div          = is_div(r_f3);
  assign w_trial           = r_acc[AW-1:WIDTH-1];
  assign w_add_a           = w_is_div ? w_trial : {1'b0, r_acc[AW-1:WIDTH]};
  assign w_add_b           = w_is_div ? ~{1'b0, r_mag_b} : {1'b0, r_mag_b};
  assign {w_cout, w_sum}   = {1'b0, w_add_a} + {1'b0, w_add_b} + (WIDTH+2)'(w_is_div);
  assign w_acc_mul         = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[AW-1:1]};
  assign w_rem_nxt         = w_cout ? w_sum[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_acc_div         = {w_rem_nxt, r_acc[WIDTH-2:0], w_cout};

  // Sign correction and result select
  logic [AW-1:0]    w_prod;
  logic [WIDTH-1:0] w_quot, w_rem, w_final;

  assign w_prod = r_neg ? (~r_acc + AW'(1)) : r_acc;
  assign w_quot = r_neg ? (~r_acc[WIDTH-1:0] + WIDTH'(1)) : r_acc[WIDTH-1:0];
  assign w_rem  = r_sa ? (~r_acc[AW-1:WIDTH] + WIDTH'(1)) : r_acc[AW-1:WIDTH];

  always_comb begin
    w_final = w_rem;
    case (r_f3)
      F3_MUL:                       w_final = w_prod[WIDTH-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_final = w_prod[AW-1:WIDTH];
      F3_DIV, F3_DIVU:              w_final = w_quot;
      default:                      w_final = w_rem;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state; kill wins over both issue and completion
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i && !kill_i) begin
          w_start     = 1'b1;
          w_state_nxt = w_fast ? FIN : CALC;
        end
      end
      CALC: begin
        if (kill_i)              w_state_nxt = IDLE;
        else if (r_cnt == '0)    w_state_nxt = FIN;
      end
      FIN: begin
        w_state_nxt = IDLE;
        w_done      = !kill_i;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_f3     <= F3_MUL;
      r_acc    <= '0;
      r_mag_b  <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_sa     <= 1'b0;
      r_result <= '0;
    end else begin
      if (w_start) begin
        r_f3    <= w_f3_in;
        r_mag_b <= w_mag_b;
        r_cnt   <= CW'(WIDTH - 1);
        r_acc   <= w_fast ? w_fast_acc : {{WIDTH{1'b0}}, w_mag_a};
        r_neg   <= w_fast ? 1'b0 : (w_sa ^ w_sb);
        r_sa    <= w_fast ? 1'b0 : w_sa;
      end else if (r_state == CALC && !kill_i) begin
        r_acc <= w_is_div ? w_acc_div : w_acc_mul;
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_done) r_result <= w_final;
    end
  end

  assign busy_o   = (r_state == CALC);
  assign done_o   = w_done;
  assign result_o = w_done ? w_final : r_result;

endmodule
